prog_loader: RTL

Program loader that writes a byte stream into `mem` through a valid/ready handshake, then optionally reads the range back and checks it against a signature. It is the writer counterpart to `fetcher`, which only reads program bytes. It sits beside `mem` and owns the memory bus (`bus_own`) while it runs. The CPU datapath then fetches from the loaded image. It replaces the bench-driven `manual_mem` load path.

---
 rtl/prog_loader_pkg.sv | 36 +++
 rtl/prog_loader_signature.sv | 40 ++++
 rtl/prog_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared states, widths and bus-select define for the program loader.
// Optional read-back verification is enabled by defining PROG_LOADER_VERIFY_EN.
`ifndef PROG_LOADER_PKG_DEFS
`define PROG_LOADER_PKG_DEFS
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef SIG_WIDTH
`define SIG_WIDTH 16
`endif
// Top-level mem mux select value meaning "loader drives the bus"
`define LDR_BUS_SEL 1'b1
`endif

package prog_loader_pkg;

    localparam logic [2:0] LDR_IDLE  = 3'd0;
    localparam logic [2:0] LDR_WRITE = 3'd1;
    localparam logic [2:0] LDR_VREAD = 3'd2;
    localparam logic [2:0] LDR_VLAST = 3'd3;
    localparam logic [2:0] LDR_DONE  = 3'd4;
    localparam logic [2:0] LDR_ERROR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = LDR_IDLE,
        ST_WRITE = LDR_WRITE,
        ST_VREAD = LDR_VREAD,
        ST_VLAST = LDR_VLAST,
        ST_DONE  = LDR_DONE,
        ST_ERROR = LDR_ERROR
    } ldr_state_e;

endpackage

// File: rtl/prog_loader_signature.sv
// Signature accumulator {sum mod 2^DATA_WIDTH, running XOR}; sig_nxt is the
// value the signature would take if din were folded in this cycle.
module loader_signature
    import prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH = `REG_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic [2*DATA_WIDTH-1:0]   sig,
    output logic [2*DATA_WIDTH-1:0]   sig_nxt
);

    logic [DATA_WIDTH-1:0] sum_r;
    logic [DATA_WIDTH-1:0] xor_r;

    assign sig     = {sum_r, xor_r};
    assign sig_nxt = {sum_r + din, xor_r ^ din};

    // Accumulator registers; clear wins over enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= {DATA_WIDTH{1'b0}};
            xor_r <= {DATA_WIDTH{1'b0}};
        end else if (clr) begin
            sum_r <= {DATA_WIDTH{1'b0}};
            xor_r <= {DATA_WIDTH{1'b0}};
        end else if (en) begin
            sum_r <= sum_r + din;
            xor_r <= xor_r ^ din;
        end else begin
            sum_r <= sum_r;
            xor_r <= xor_r;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams bytes into mem over valid/ready, optionally reading the
// range back and comparing signatures when PROG_LOADER_VERIFY_EN is defined.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  bus_own,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    ldr_state_e state_r, state_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s, len_r, len_s, cnt_r, cnt_s, addr_r, addr_s;
    logic [ADDR_WIDTH-1:0] cnt_inc_s;
    logic [DATA_WIDTH-1:0] din_r, din_s;
    logic we_r, we_s, rdy_r, rdy_s, busy_r, busy_s, done_r, done_s, err_r, err_s;
    logic hs_s, wclr_s, wen_s;
    logic [2*DATA_WIDTH-1:0] wsig_s, wsig_nxt_s;
    logic sig_unused_s;

    assign hs_s      = in_valid & rdy_r;
    assign cnt_inc_s = cnt_r + ADDR_ONE;

    loader_signature #(.DATA_WIDTH(DATA_WIDTH)) u_wsig (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wclr_s),
        .en      (wen_s),
        .din     (in_data),
        .sig     (wsig_s),
        .sig_nxt (wsig_nxt_s)
    );

`ifdef PROG_LOADER_VERIFY_EN
    logic [ADDR_WIDTH-1:0] iss_r, iss_s;
    logic pend1_r, pend1_s, pend2_r, pend2_s;
    logic [2*DATA_WIDTH-1:0] rsig_s, rsig_nxt_s;

    // pend2_r marks the cycle in which mem_dout answers an issued read
    loader_signature #(.DATA_WIDTH(DATA_WIDTH)) u_rsig (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wclr_s),
        .en      (pend2_r),
        .din     (mem_dout),
        .sig     (rsig_s),
        .sig_nxt (rsig_nxt_s)
    );

    assign sig_unused_s = ^{wsig_nxt_s, rsig_s};
`else
    assign sig_unused_s = ^{wsig_nxt_s, wsig_s, mem_dout};
`endif

    // Next-state and next-output logic; outputs idle unless a phase drives them
    always_comb begin
        state_s = state_r;
        base_s  = base_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        addr_s  = ADDR_ZERO;
        din_s   = {DATA_WIDTH{1'b0}};
        we_s    = 1'b0;
        rdy_s   = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        err_s   = err_r;
        wclr_s  = 1'b0;
        wen_s   = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
        iss_s   = iss_r;
        pend1_s = 1'b0;
        pend2_s = pend1_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    base_s = base_addr;
                    len_s  = length;
                    cnt_s  = ADDR_ZERO;
                    wclr_s = 1'b1;
                    err_s  = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
                    iss_s  = ADDR_ZERO;
`endif
                    if (length == ADDR_ZERO) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_WRITE;
                        rdy_s   = 1'b1;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_WRITE: begin
                busy_s = 1'b1;
                rdy_s  = 1'b1;
                if (hs_s) begin
                    we_s   = 1'b1;
                    addr_s = base_r + cnt_r;
                    din_s  = in_data;
                    wen_s  = 1'b1;
                    cnt_s  = cnt_inc_s;
                    // busy stays high through the cycle that carries the final write
                    if (cnt_inc_s == len_r) begin
                        rdy_s = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
                        state_s = ST_VREAD;
`else
                        state_s = ST_DONE;
                        done_s  = 1'b1;
`endif
                    end else begin
                        state_s = ST_WRITE;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
`ifdef PROG_LOADER_VERIFY_EN
            ST_VREAD: begin
                busy_s  = 1'b1;
                addr_s  = base_r + iss_r;
                iss_s   = iss_r + ADDR_ONE;
                pend1_s = 1'b1;
                if ((iss_r + ADDR_ONE) == len_r) begin
                    state_s = ST_VLAST;
                end else begin
                    state_s = ST_VREAD;
                end
            end
            ST_VLAST: begin
                busy_s = 1'b1;
                // Final byte is on mem_dout and nothing is still in flight
                if (pend2_r && !pend1_r) begin
                    busy_s = 1'b0;
                    if (wsig_s == rsig_nxt_s) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_ERROR;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_VLAST;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            base_r  <= ADDR_ZERO;
            len_r   <= ADDR_ZERO;
            cnt_r   <= ADDR_ZERO;
            addr_r  <= ADDR_ZERO;
            din_r   <= {DATA_WIDTH{1'b0}};
            we_r    <= 1'b0;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            base_r  <= base_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            din_r   <= din_s;
            we_r    <= we_s;
            rdy_r   <= rdy_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

`ifdef PROG_LOADER_VERIFY_EN
    // Read-issue counter and read-latency tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_r   <= ADDR_ZERO;
            pend1_r <= 1'b0;
            pend2_r <= 1'b0;
        end else begin
            iss_r   <= iss_s;
            pend1_r <= pend1_s;
            pend2_r <= pend2_s;
        end
    end

    assign error = err_r;
`else
    assign error = 1'b0;
`endif

    assign in_ready = rdy_r;
    assign mem_we   = we_r;
    assign mem_addr = addr_r;
    assign mem_din  = din_r;
    assign bus_own  = busy_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
